// File: rtl/jtcop_obj_scan_if.sv
// Draw-request channel between the object table scanner and the line-buffer drawer.
// The scanner (master) offers one sprite-line request at a time with dr_valid. The
// drawer (slave) takes it on any clock edge where dr_valid and dr_ready are both high.
//   dr_valid  request valid (master -> slave)
//   dr_ready  drawer can accept (slave -> master)
//   dr_code   tile code for this line, with the tile row already added
//   dr_vrow   pixel row inside the 16x16 tile, with vflip already applied
//   dr_xpos   sprite X
//   dr_pal    palette
//   dr_hflip  horizontal flip
interface jtcop_obj_scan_if;
  logic        dr_valid;
  logic        dr_ready;
  logic [11:0] dr_code;
  logic [3:0]  dr_vrow;
  logic [8:0]  dr_xpos;
  logic [3:0]  dr_pal;
  logic        dr_hflip;

  modport master (
    output dr_valid, dr_code, dr_vrow, dr_xpos, dr_pal, dr_hflip,
    input  dr_ready
  );

  modport slave (
    input  dr_valid, dr_code, dr_vrow, dr_xpos, dr_pal, dr_hflip,
    output dr_ready
  );
endinterface

// File: rtl/jtcop_obj_scan.sv
// Object table scanner. Once per line it walks the sprite table from entry ENTRIES-1
// down to 0, so entry 0 is drawn last and has the highest priority. For every entry
// whose vertical span covers vrender, it hands a request to the line drawer.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   hinit        line-start strobe; (re)starts the scan from any state
//   vrender      line being prepared
//   tbl_addr     object table address {entry, word}
//   tbl_dout     object table data, one clock after tbl_addr
//   dr           draw-request channel (master side)
//   scan_done    high from the end of the scan until the next hinit
module jtcop_obj_scan #(
  parameter int         ENTRIES = 256,
  parameter logic [8:0] YOFS    = 9'd0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hinit,
  input  logic [8:0]       vrender,
  output logic [9:0]       tbl_addr,
  input  logic [15:0]      tbl_dout,
  jtcop_obj_scan_if.master dr,
  output logic             scan_done
);

  localparam logic [7:0] LAST = 8'(ENTRIES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD0   = 3'd1,
    S_CHK   = 3'd2,
    S_RD1   = 3'd3,
    S_RD2   = 3'd4,
    S_ISSUE = 3'd5,
    S_NEXT  = 3'd6,
    S_DONE  = 3'd7
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  entry_q, entry_d;
  logic [9:0]  addr_q, addr_d;
  logic [6:0]  ydiff_q, ydiff_d;      // only the bits inside a 128-line sprite matter
  logic [1:0]  msize_q, msize_d;
  logic        vflip_q, vflip_d;
  logic        hflip_q, hflip_d;
  logic        valid_q, valid_d;
  logic [11:0] code_q, code_d;
  logic [3:0]  vrow_q, vrow_d;
  logic [8:0]  xpos_q, xpos_d;
  logic [3:0]  pal_q, pal_d;
  logic        hflip_out_q, hflip_out_d;
  logic        done_q, done_d;

  logic [8:0]  ydiff_s;
  logic [8:0]  height_s;
  logic        hit_s;
  logic [2:0]  mask_s;
  logic [2:0]  row_s;
  logic [2:0]  tilerow_s;

  // Vertical hit test on word 0. The subtraction wraps mod 512, so a sprite can start
  // near the bottom of the Y range and still cover the top lines.
  always_comb begin
    ydiff_s  = vrender - (tbl_dout[8:0] + YOFS);
    height_s = 9'd16 << tbl_dout[12:11];
    hit_s    = tbl_dout[15] & (ydiff_s < height_s);
  end

  // Tile row inside a tall sprite. It is limited to the sprite height and mirrored on vflip.
  always_comb begin
    case (msize_q)
      2'd0:    mask_s = 3'd0;
      2'd1:    mask_s = 3'd1;
      2'd2:    mask_s = 3'd3;
      default: mask_s = 3'd7;
    endcase
    row_s = ydiff_q[6:4] & mask_s;
    if (vflip_q) begin
      tilerow_s = mask_s - row_s;
    end else begin
      tilerow_s = row_s;
    end
  end

  // Scan FSM. The address leads the state by one clock so the RAM's one-clock latency
  // lines up: w0 shows up in CHK, w1 in RD1 and w2 in RD2.
  always_comb begin
    state_d     = state_q;
    entry_d     = entry_q;
    addr_d      = addr_q;
    ydiff_d     = ydiff_q;
    msize_d     = msize_q;
    vflip_d     = vflip_q;
    hflip_d     = hflip_q;
    valid_d     = valid_q;
    code_d      = code_q;
    vrow_d      = vrow_q;
    xpos_d      = xpos_q;
    pal_d       = pal_q;
    hflip_out_d = hflip_out_q;
    done_d      = done_q;
    if (hinit) begin
      // A line start always restarts the scan. Any request not yet accepted is dropped.
      state_d = S_RD0;
      entry_d = LAST;
      addr_d  = {LAST, 2'd0};
      valid_d = 1'b0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done_d = 1'b1;
        end
        S_RD0: begin
          addr_d  = {entry_q, 2'd1};
          state_d = S_CHK;
        end
        S_CHK: begin
          ydiff_d = ydiff_s[6:0];
          msize_d = tbl_dout[12:11];
          vflip_d = tbl_dout[14];
          hflip_d = tbl_dout[13];
          if (hit_s) begin
            addr_d  = {entry_q, 2'd2};
            state_d = S_RD1;
          end else begin
            state_d = S_NEXT;
          end
        end
        S_RD1: begin
          code_d      = tbl_dout[11:0] + {9'd0, tilerow_s};
          vrow_d      = ydiff_q[3:0] ^ {4{vflip_q}};
          hflip_out_d = hflip_q;
          state_d     = S_RD2;
        end
        S_RD2: begin
          xpos_d  = tbl_dout[8:0];
          pal_d   = tbl_dout[15:12];
          valid_d = 1'b1;
          state_d = S_ISSUE;
        end
        S_ISSUE: begin
          if (dr.dr_ready) begin
            valid_d = 1'b0;
            state_d = S_NEXT;
          end else begin
            state_d = S_ISSUE;
          end
        end
        S_NEXT: begin
          if (entry_q == 8'd0) begin
            state_d = S_DONE;
          end else begin
            entry_d = entry_q - 8'd1;
            addr_d  = {entry_d, 2'd0};
            state_d = S_RD0;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      entry_q     <= LAST;
      addr_q      <= 10'd0;
      ydiff_q     <= 7'd0;
      msize_q     <= 2'd0;
      vflip_q     <= 1'b0;
      hflip_q     <= 1'b0;
      valid_q     <= 1'b0;
      code_q      <= 12'd0;
      vrow_q      <= 4'd0;
      xpos_q      <= 9'd0;
      pal_q       <= 4'd0;
      hflip_out_q <= 1'b0;
      done_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      entry_q     <= entry_d;
      addr_q      <= addr_d;
      ydiff_q     <= ydiff_d;
      msize_q     <= msize_d;
      vflip_q     <= vflip_d;
      hflip_q     <= hflip_d;
      valid_q     <= valid_d;
      code_q      <= code_d;
      vrow_q      <= vrow_d;
      xpos_q      <= xpos_d;
      pal_q       <= pal_d;
      hflip_out_q <= hflip_out_d;
      done_q      <= done_d;
    end
  end

  assign tbl_addr    = addr_q;
  assign scan_done   = done_q;
  assign dr.dr_valid = valid_q;
  assign dr.dr_code  = code_q;
  assign dr.dr_vrow  = vrow_q;
  assign dr.dr_xpos  = xpos_q;
  assign dr.dr_pal   = pal_q;
  assign dr.dr_hflip = hflip_out_q;

endmodule

// File: tb/tb_jtcop_obj_scan.sv
// Testbench for jtcop_obj_scan. A behavioural table RAM and a drawer sink surround the
// DUT. Each accepted request is compared against a list of hits worked out directly
// from the sprite table contents.
module tb_jtcop_obj_scan;
  localparam int ENTRIES = 256;
  localparam int YOFS    = 0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hinit;
  logic [8:0]  vrender;
  logic [9:0]  tbl_addr;
  logic [15:0] tbl_dout;
  logic        scan_done;

  jtcop_obj_scan_if dr_if();

  jtcop_obj_scan #(.ENTRIES(ENTRIES), .YOFS(9'(YOFS))) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .hinit     (hinit),
    .vrender   (vrender),
    .tbl_addr  (tbl_addr),
    .tbl_dout  (tbl_dout),
    .dr        (dr_if),
    .scan_done (scan_done)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [1024];
  always @(posedge clk) tbl_dout <= mem[tbl_addr];

  typedef struct packed {
    logic [11:0] code;
    logic [3:0]  vrow;
    logic [8:0]  x;
    logic [3:0]  pal;
    logic        hf;
  } req_t;

  req_t got_q[$];
  req_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   rnd_ready = 1'b0;

  // Drawer sink: record each handshake half a cycle before the edge that completes it.
  always @(negedge clk)
    if (rst_n === 1'b1 && dr_if.dr_valid === 1'b1 && dr_if.dr_ready === 1'b1)
      got_q.push_back({dr_if.dr_code, dr_if.dr_vrow, dr_if.dr_xpos, dr_if.dr_pal, dr_if.dr_hflip});

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: the hits for one line in scan order, from the entry format rules.
  function automatic void build_expect(input int vr);
    exp_q.delete();
    for (int e = ENTRIES - 1; e >= 0; e--) begin
      int w0, w1, w2, ysz, yd, rows, tr, vf;
      req_t r;
      w0  = int'(mem[e*4]);
      w1  = int'(mem[e*4+1]);
      w2  = int'(mem[e*4+2]);
      ysz = 16 << ((w0 >> 11) & 3);
      yd  = (vr - (w0 & 511) - YOFS) & 511;
      if (((w0 >> 15) & 1) == 1 && yd < ysz) begin
        rows = ysz / 16;
        tr   = (yd / 16) % rows;
        vf   = (w0 >> 14) & 1;
        if (vf == 1) tr = rows - 1 - tr;
        r.code = 12'((w1 & 4095) + tr);
        r.vrow = 4'((vf == 1) ? 15 - (yd % 16) : (yd % 16));
        r.x    = 9'(w2 & 511);
        r.pal  = 4'((w2 >> 12) & 15);
        r.hf   = 1'((w0 >> 13) & 1);
        exp_q.push_back(r);
      end
    end
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) mem[i] = 16'd0;
  endtask

  task automatic set_entry(input int e, input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2);
    mem[e*4]   = w0;
    mem[e*4+1] = w1;
    mem[e*4+2] = w2;
    mem[e*4+3] = 16'($urandom);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (scan_done !== 1'b1 && n < 6000) begin
      if (rnd_ready) dr_if.dr_ready = 1'($urandom);
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_done_in_time"}, 32'(n < 6000), 32'd1);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (dr_if.dr_valid !== 1'b1 && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_valid_in_time"}, 32'(n < 3000), 32'd1);
  endtask

  task automatic pulse_hinit();
    hinit = 1'b1;
    @(posedge clk); #1;
    hinit = 1'b0;
  endtask

  task automatic cmp_lists(input string tag);
    int n;
    chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_req%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  task automatic run_line(input int vr, input string tag);
    @(posedge clk); #1;
    build_expect(vr);
    got_q.delete();
    vrender = 9'(vr);
    pulse_hinit();
    wait_done(tag);
    @(negedge clk);
    cmp_lists(tag);
  endtask

  initial begin
    int n;
    int vr;
    bit stable;
    req_t snap;

    rst_n = 1'b0;
    hinit = 1'b0;
    vrender = 9'd0;
    dr_if.dr_ready = 1'b0;
    clear_mem();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_addr", 32'(tbl_addr), 32'd0);
    chk("rst_valid", 32'(dr_if.dr_valid), 32'd0);
    chk("rst_code", 32'(dr_if.dr_code), 32'd0);
    chk("rst_vrow", 32'(dr_if.dr_vrow), 32'd0);
    chk("rst_xpos", 32'(dr_if.dr_xpos), 32'd0);
    chk("rst_pal", 32'(dr_if.dr_pal), 32'd0);
    chk("rst_hflip", 32'(dr_if.dr_hflip), 32'd0);
    chk("rst_done", 32'(scan_done), 32'd1);
    rst_n = 1'b1;

    // Empty table: no requests, and the scan length is exactly 3 clocks per entry plus 2.
    dr_if.dr_ready = 1'b1;
    got_q.delete();
    @(posedge clk); #1;
    pulse_hinit();
    chk("busy_after_hinit", 32'(scan_done), 32'd0);
    chk("first_addr", 32'(tbl_addr), 32'h3FC);
    n = 1;
    while (scan_done !== 1'b1 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_latency", 32'(n), 32'(3 * ENTRIES + 2));
    chk("empty_no_req", 32'(got_q.size()), 32'd0);

    // Single plain sprite.
    clear_mem();
    set_entry(5, 16'h8010, 16'h0123, 16'h3040);
    run_line(9'h015, "e5");
    if (got_q.size() > 0) begin
      chk("e5_code", 32'(got_q[0].code), 32'h123);
      chk("e5_vrow", 32'(got_q[0].vrow), 32'h5);
      chk("e5_x", 32'(got_q[0].x), 32'h040);
      chk("e5_pal", 32'(got_q[0].pal), 32'h3);
      chk("e5_hflip", 32'(got_q[0].hf), 32'h0);
    end

    // 128-line sprite with both flips.
    clear_mem();
    set_entry(7, 16'hF810, 16'h0200, 16'h1055);
    run_line(9'h010 + 37, "e7");
    if (got_q.size() > 0) begin
      chk("e7_code", 32'(got_q[0].code), 32'h205);
      chk("e7_vrow", 32'(got_q[0].vrow), 32'hA);
      chk("e7_hflip", 32'(got_q[0].hf), 32'h1);
    end

    // Y wrap around 512 and code wrap past 0xFFF.
    clear_mem();
    set_entry(3, 16'h89F4, 16'h0FFF, 16'h2111);
    run_line(9'd4, "ywrap");
    if (got_q.size() > 0) begin
      chk("ywrap_code", 32'(got_q[0].code), 32'h000);
      chk("ywrap_vrow", 32'(got_q[0].vrow), 32'h0);
    end

    // Two hits, with the drawer stalling on the first one.
    clear_mem();
    set_entry(9, 16'h8078, 16'h00AB, 16'h5123);
    set_entry(2, 16'hA07C, 16'h07FE, 16'h9011);
    build_expect(9'h080);
    got_q.delete();
    vrender = 9'h080;
    dr_if.dr_ready = 1'b0;
    @(posedge clk); #1;
    pulse_hinit();
    wait_valid("stall");
    snap = {dr_if.dr_code, dr_if.dr_vrow, dr_if.dr_xpos, dr_if.dr_pal, dr_if.dr_hflip};
    stable = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      if (dr_if.dr_valid !== 1'b1 ||
          {dr_if.dr_code, dr_if.dr_vrow, dr_if.dr_xpos, dr_if.dr_pal, dr_if.dr_hflip} !== snap)
        stable = 1'b0;
    end
    chk("stall_stable", 32'(stable), 32'd1);
    if (exp_q.size() > 0) chk("stall_first_is_e9", 32'(snap), 32'(exp_q[0]));
    dr_if.dr_ready = 1'b1;
    wait_done("stall");
    @(negedge clk);
    cmp_lists("stall");

    // A line start while a request is pending drops it and restarts from the top entry.
    got_q.delete();
    dr_if.dr_ready = 1'b0;
    @(posedge clk); #1;
    pulse_hinit();
    wait_valid("abort");
    pulse_hinit();
    chk("abort_valid_drop", 32'(dr_if.dr_valid), 32'd0);
    chk("abort_addr", 32'(tbl_addr), 32'h3FC);
    chk("abort_busy", 32'(scan_done), 32'd0);
    dr_if.dr_ready = 1'b1;
    wait_done("abort");
    @(negedge clk);
    cmp_lists("abort");

    // Random tables with a randomly stalling drawer.
    for (int l = 0; l < 5; l++) begin
      clear_mem();
      vr = int'($urandom_range(0, 511));
      for (int k = 0; k < 16; k++) begin
        int e, y, w0;
        e  = int'($urandom_range(0, ENTRIES - 1));
        y  = (vr - int'($urandom_range(0, 150))) & 511;
        w0 = ((($urandom_range(0, 3) != 0) ? 1 : 0) << 15) | (int'($urandom_range(0, 1)) << 14) |
             (int'($urandom_range(0, 1)) << 13) | (int'($urandom_range(0, 3)) << 11) | y;
        set_entry(e, 16'(w0), 16'($urandom), 16'($urandom));
      end
      rnd_ready = 1'b1;
      run_line(vr, $sformatf("rand%0d", l));
      rnd_ready = 1'b0;
    end

    // Reset in the middle of a scan.
    clear_mem();
    set_entry(9, 16'h8078, 16'h00AB, 16'h5123);
    got_q.delete();
    vrender = 9'h080;
    dr_if.dr_ready = 1'b0;
    @(posedge clk); #1;
    pulse_hinit();
    wait_valid("midrst");
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_addr", 32'(tbl_addr), 32'd0);
    chk("midrst_valid", 32'(dr_if.dr_valid), 32'd0);
    chk("midrst_code", 32'(dr_if.dr_code), 32'd0);
    chk("midrst_xpos", 32'(dr_if.dr_xpos), 32'd0);
    chk("midrst_pal", 32'(dr_if.dr_pal), 32'd0);
    chk("midrst_done", 32'(scan_done), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    dr_if.dr_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("postrst_valid", 32'(dr_if.dr_valid), 32'd0);
    chk("postrst_no_req", 32'(got_q.size()), 32'd0);
    chk("postrst_done", 32'(scan_done), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
